// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard issuing an in-order prefix of a multi-lane bundle
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   valid_i                      lane holds an instruction (lane 0 oldest)
//   rs_i, rt_i                   5-bit source register numbers per lane
//   read_rs_i, read_rt_i         source operand is used
//   regwrite_i, writereg_i       lane writes a destination register
//   lat_i                        cycles until the result is forwardable (1..MAXLAT)
//   backend_stall_i              freezes the scoreboard, no issue
//   flush_i                      clears all pending state, no issue
//   grant_o                      issuing lanes, always a prefix mask
//   issue_count_o                popcount of grant_o
//   stall_front_o                a valid lane was held back, or backend stall
//   stall_cycles_o               saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int LANES  = 2,
    parameter int NREG   = 32,
    parameter int MAXLAT = 4,
    localparam int CW = $clog2(MAXLAT + 1),
    localparam int IW = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      valid_i,
    input  logic [LANES*5-1:0]    rs_i,
    input  logic [LANES*5-1:0]    rt_i,
    input  logic [LANES-1:0]      read_rs_i,
    input  logic [LANES-1:0]      read_rt_i,
    input  logic [LANES-1:0]      regwrite_i,
    input  logic [LANES*5-1:0]    writereg_i,
    input  logic [LANES*CW-1:0]   lat_i,
    input  logic                  backend_stall_i,
    input  logic                  flush_i,
    output logic [LANES-1:0]      grant_o,
    output logic [IW-1:0]         issue_count_o,
    output logic                  stall_front_o,
    output logic [31:0]           stall_cycles_o
);
    logic [CW-1:0]  cnt_q [NREG];
    logic [CW-1:0]  cnt_d [NREG];
    logic [31:0]    stall_cycles_q;
    logic [LANES-1:0] ok;
    logic [LANES:0]   chain;

    function automatic logic [4:0] fld(input logic [LANES*5-1:0] v, input int k);
        return v[k*5 +: 5];
    endfunction

    function automatic logic [CW-1:0] lt(input logic [LANES*CW-1:0] v, input int k);
        logic [CW-1:0] l;
        l = v[k*CW +: CW];
        return l > CW'(MAXLAT) ? CW'(MAXLAT) : l;
    endfunction

    // A producer loaded with lat L reads L in the cycle after issue and is
    // forwardable once the count reaches 1, so a consumer issues exactly L
    // cycles after its producer.
    always_comb begin
        ok = '0;
        for (int k = 0; k < LANES; k++) begin
            ok[k] = valid_i[k]
                && !(read_rs_i[k] && fld(rs_i, k) != 5'd0 && cnt_q[fld(rs_i, k)] > CW'(1))
                && !(read_rt_i[k] && fld(rt_i, k) != 5'd0 && cnt_q[fld(rt_i, k)] > CW'(1))
                && !(regwrite_i[k] && fld(writereg_i, k) != 5'd0
                     && cnt_q[fld(writereg_i, k)] > lt(lat_i, k));
            for (int i = 0; i < k; i++) begin
                if (regwrite_i[i] && fld(writereg_i, i) != 5'd0) begin
                    if ((read_rs_i[k] && fld(rs_i, k) == fld(writereg_i, i))
                        || (read_rt_i[k] && fld(rt_i, k) == fld(writereg_i, i)))
                        ok[k] = 1'b0;
                    if (regwrite_i[k] && fld(writereg_i, k) == fld(writereg_i, i)
                        && lt(lat_i, i) > lt(lat_i, k))
                        ok[k] = 1'b0;
                end
            end
        end
    end

    // Grant chain makes the issue mask a prefix: a held lane holds all younger ones.
    always_comb begin
        chain[0] = !rst && !backend_stall_i && !flush_i;
        issue_count_o = '0;
        for (int k = 0; k < LANES; k++) begin
            chain[k+1] = chain[k] && ok[k];
            issue_count_o = issue_count_o + IW'(chain[k+1]);
        end
        grant_o = chain[LANES:1];
        stall_front_o = !rst && !flush_i && ((|(valid_i & ~grant_o)) || backend_stall_i);
    end

    // Loads apply in lane order, so the youngest granted writer of a register wins.
    always_comb begin
        for (int r = 0; r < NREG; r++)
            cnt_d[r] = cnt_q[r] != '0 ? cnt_q[r] - CW'(1) : '0;
        for (int k = 0; k < LANES; k++)
            if (grant_o[k] && regwrite_i[k] && fld(writereg_i, k) != 5'd0)
                cnt_d[fld(writereg_i, k)] = lt(lat_i, k);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i)
            cnt_q <= '{default: '0};
        else if (!backend_stall_i)
            cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_q <= '0;
        else if ((stall_front_o || backend_stall_i) && stall_cycles_q != '1)
            stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign stall_cycles_o = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;
    localparam int LN = 4;
    localparam int NR = 32;
    localparam int ML = 4;
    localparam int CW = $clog2(ML + 1);
    localparam int IW = $clog2(LN + 1);

    logic clk = 1'b0;
    logic rst, bs, fl;
    logic [LN-1:0] v, ds, dt, dw;
    logic [4:0] s [LN];
    logic [4:0] t [LN];
    logic [4:0] w [LN];
    logic [CW-1:0] l [LN];
    logic [LN*5-1:0] rs_p, rt_p, wr_p;
    logic [LN*CW-1:0] lat_p;
    logic [LN-1:0] grant_o;
    logic [IW-1:0] issue_count_o;
    logic stall_front_o;
    logic [31:0] stall_cycles_o;

    int n_chk = 0;
    int n_pass = 0;
    int avail [NR];
    int now = 0;
    logic [31:0] sc_m = '0;
    logic [LN-1:0] g_m;
    logic sf_m;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < LN; k++) begin
            rs_p[k*5 +: 5] = s[k];
            rt_p[k*5 +: 5] = t[k];
            wr_p[k*5 +: 5] = w[k];
            lat_p[k*CW +: CW] = l[k];
        end
    end

    hazard_scoreboard #(.LANES(LN), .NREG(NR), .MAXLAT(ML)) dut (
        .clk(clk), .rst(rst), .valid_i(v), .rs_i(rs_p), .rt_i(rt_p),
        .read_rs_i(ds), .read_rt_i(dt), .regwrite_i(dw), .writereg_i(wr_p),
        .lat_i(lat_p), .backend_stall_i(bs), .flush_i(fl), .grant_o(grant_o),
        .issue_count_o(issue_count_o), .stall_front_o(stall_front_o),
        .stall_cycles_o(stall_cycles_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // avail[r] is the first cycle a consumer of r may issue; -1 means no result in flight.
    function automatic logic [LN-1:0] model_grant();
        logic [LN-1:0] g;
        logic pre;
        g = '0;
        pre = !rst && !bs && !fl;
        for (int k = 0; k < LN; k++) begin
            logic ok;
            ok = v[k];
            if (ds[k] && s[k] != 0 && avail[s[k]] > now) ok = 0;
            if (dt[k] && t[k] != 0 && avail[t[k]] > now) ok = 0;
            if (dw[k] && w[k] != 0 && avail[w[k]] >= now && avail[w[k]] - now + 1 > int'(l[k])) ok = 0;
            for (int i = 0; i < k; i++)
                if (dw[i] && w[i] != 0) begin
                    if ((ds[k] && s[k] == w[i]) || (dt[k] && t[k] == w[i])) ok = 0;
                    if (dw[k] && w[k] == w[i] && l[i] > l[k]) ok = 0;
                end
            pre = pre && ok;
            g[k] = pre;
        end
        return g;
    endfunction

    task automatic eval();
        g_m = model_grant();
        sf_m = !rst && !fl && ((|(v & ~g_m)) || bs);
        @(negedge clk);
        check("grant", 32'(grant_o), 32'(g_m));
        check("issue_count", 32'(issue_count_o), $countones(g_m));
        check("stall_front", 32'(stall_front_o), 32'(sf_m));
        check("stall_cycles", stall_cycles_o, sc_m);
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst || fl) begin
            foreach (avail[r]) avail[r] = -1;
        end else if (bs) begin
            foreach (avail[r]) if (avail[r] >= now) avail[r]++;
        end else begin
            for (int k = 0; k < LN; k++)
                if (g_m[k] && dw[k] && w[k] != 0) avail[w[k]] = now + int'(l[k]);
        end
        if (rst) sc_m = '0;
        else if ((sf_m || bs) && sc_m != 32'hFFFF_FFFF) sc_m++;
        now++;
        #1;
    endtask

    task automatic clr();
        v = '0; ds = '0; dt = '0; dw = '0; rst = 0; bs = 0; fl = 0;
        for (int k = 0; k < LN; k++) begin
            s[k] = '0; t[k] = '0; w[k] = '0; l[k] = CW'(1);
        end
    endtask

    task automatic lane(input int k, input logic [4:0] a, input logic ra, input logic [4:0] b,
                        input logic rb, input logic we, input logic [4:0] d, input int lt);
        v[k] = 1; s[k] = a; ds[k] = ra; t[k] = b; dt[k] = rb; dw[k] = we; w[k] = d; l[k] = CW'(lt);
    endtask

    task automatic reset();
        clr();
        for (int k = 0; k < LN; k++) lane(k, 5'd5, 1, 5'd6, 1, 1, 5'd7, 2);
        rst = 1; bs = 1;
        eval();
        check("rst_grant", 32'(grant_o), 0);
        adv();
        clr();
    endtask

    initial begin
        foreach (avail[r]) avail[r] = -1;
        clr();
        rst = 1;
        @(posedge clk); #1;
        reset();
        // load-use: r5 lat 2 stalls the next reader one cycle
        lane(0, 0, 0, 0, 0, 1, 5'd5, 2); eval(); check("lu_prod", 32'(grant_o), 1); adv();
        clr(); lane(0, 5'd5, 1, 0, 0, 0, 0, 1);
        eval(); check("lu_stall", 32'(grant_o), 0); adv();
        eval(); check("lu_grant", 32'(grant_o), 1); check("lu_cycles", stall_cycles_o, 1); adv();
        // intra-bundle RAW
        reset();
        lane(0, 0, 0, 0, 0, 1, 5'd3, 1); lane(1, 5'd3, 1, 0, 0, 0, 0, 1);
        eval(); check("raw_grant", 32'(grant_o), 1); check("raw_cnt", 32'(issue_count_o), 1);
        check("raw_sf", 32'(stall_front_o), 1); adv();
        clr(); lane(0, 5'd3, 1, 0, 0, 0, 0, 1); eval(); check("raw_next", 32'(grant_o), 1); adv();
        // prefix: lane 1 blocked holds ready lanes 2 and 3
        reset();
        lane(0, 0, 0, 0, 0, 1, 5'd2, 1); lane(1, 0, 0, 5'd2, 1, 0, 0, 1);
        lane(2, 5'd10, 1, 0, 0, 0, 0, 1); lane(3, 5'd11, 1, 0, 0, 0, 0, 1);
        eval(); check("prefix", 32'(grant_o), 1); adv();
        // freeze under backend stall
        reset();
        lane(0, 0, 0, 0, 0, 1, 5'd7, 3); eval(); adv();
        clr(); lane(0, 5'd7, 1, 0, 0, 0, 0, 1); bs = 1;
        for (int i = 0; i < 5; i++) begin eval(); check("freeze", 32'(grant_o), 0); adv(); end
        bs = 0;
        eval(); check("thaw3", 32'(grant_o), 0); adv();
        eval(); check("thaw2", 32'(grant_o), 0); adv();
        eval(); check("thaw1", 32'(grant_o), 1); adv();
        // flush beats a load
        reset();
        lane(0, 0, 0, 0, 0, 1, 5'd9, 4); fl = 1; eval(); check("flush_grant", 32'(grant_o), 0); adv();
        clr(); lane(0, 5'd9, 1, 0, 0, 0, 0, 1); eval(); check("flush_read", 32'(grant_o), 1); adv();
        // r0 never stalls
        reset();
        lane(0, 0, 0, 0, 0, 1, 5'd0, 4); lane(1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 2);
        eval(); check("r0_grant", 32'(grant_o), 3); adv();
        clr(); lane(0, 5'd0, 1, 5'd0, 1, 0, 0, 1); eval(); check("r0_read", 32'(grant_o), 1); adv();
        // WAW: older longer latency blocks younger; older shorter lets youngest win
        clr(); lane(0, 0, 0, 0, 0, 1, 5'd4, 3); lane(1, 0, 0, 0, 0, 1, 5'd4, 1);
        eval(); check("waw_block", 32'(grant_o), 1); adv();
        reset();
        lane(0, 0, 0, 0, 0, 1, 5'd4, 1); lane(1, 0, 0, 0, 0, 1, 5'd4, 3);
        eval(); check("waw_both", 32'(grant_o), 3); adv();
        clr(); lane(0, 5'd4, 1, 0, 0, 0, 0, 1);
        eval(); check("waw_young1", 32'(grant_o), 0); adv();
        eval(); check("waw_young2", 32'(grant_o), 0); adv();
        eval(); check("waw_young3", 32'(grant_o), 1); adv();
        // stall counter saturation
        clr();
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        sc_m = 32'hFFFF_FFFE;
        eval(); adv();
        release dut.stall_cycles_q;
        bs = 1;
        for (int i = 0; i < 3; i++) begin eval(); adv(); end
        eval(); check("sat", stall_cycles_o, 32'hFFFF_FFFF); adv();
        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            fl = ($urandom_range(0, 24) == 0);
            bs = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < LN; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                s[k] = 5'($urandom_range(0, 7));
                t[k] = 5'($urandom_range(0, 7));
                w[k] = 5'($urandom_range(0, 7));
                ds[k] = 1'($urandom);
                dt[k] = 1'($urandom);
                dw[k] = 1'($urandom);
                l[k] = CW'($urandom_range(1, ML));
            end
            eval(); adv();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
